// File: rtl/mem_stage_if.sv
// EXE-to-MEM inputs, memory bus and writeback/branch outputs of the MEM stage.
// slave = the stage itself, master = the surrounding pipeline and memory.
interface mem_stage_if;
    logic        in_valid;
    logic [31:0] Alu_resultado;
    logic [31:0] Dato_2;
    logic [4:0]  Mux_1;
    logic        Zero_flag;
    logic [4:0]  Sumador_resultado;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic        Branch;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_regwrite;
    logic        stall;
    logic        PCSrc;
    logic [4:0]  branch_target;
    logic        mem_error;

    modport slave (
        input  in_valid, Alu_resultado, Dato_2, Mux_1, Zero_flag, Sumador_resultado,
               MemRead, MemWrite, MemtoReg, RegWrite, Branch, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_reg,
               wb_regwrite, stall, PCSrc, branch_target, mem_error
    );

    modport master (
        output in_valid, Alu_resultado, Dato_2, Mux_1, Zero_flag, Sumador_resultado,
               MemRead, MemWrite, MemtoReg, RegWrite, Branch, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_reg,
               wb_regwrite, stall, PCSrc, branch_target, mem_error
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU results pass straight to writeback, loads/stores
// wait on a one-cycle-ack memory bus with a 15-cycle timeout and sticky error.
module mem_stage (
    input  logic     clk,
    input  logic     reset,
    mem_stage_if.slave bus
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0] LAST_WAIT_CNT = 4'd14;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic        memtoreg_q, memtoreg_d;
    logic        regwrite_q, regwrite_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        pcsrc_q, pcsrc_d;
    logic [4:0]  br_tgt_q, br_tgt_d;
    logic        err_q, err_d;

    logic        mem_op;
    logic        misaligned;

    assign mem_op     = bus.MemRead | bus.MemWrite;
    assign misaligned = |bus.Alu_resultado[1:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        rd_d          = rd_q;
        memtoreg_d    = memtoreg_q;
        regwrite_d    = regwrite_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_reg_d      = wb_reg_q;
        wb_regwrite_d = wb_regwrite_q;
        pcsrc_d       = 1'b0;
        br_tgt_d      = br_tgt_q;
        err_d         = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.Branch && bus.Zero_flag) begin
                        pcsrc_d  = 1'b1;
                        br_tgt_d = bus.Sumador_resultado;
                    end
                    if (!mem_op) begin
                        wb_valid_d    = 1'b1;
                        wb_data_d     = bus.Alu_resultado;
                        wb_reg_d      = bus.Mux_1;
                        wb_regwrite_d = bus.RegWrite;
                    end else if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = S_WAIT;
                        cnt_d      = 4'd0;
                        addr_d     = bus.Alu_resultado;
                        wdata_d    = bus.Dato_2;
                        we_d       = bus.MemWrite;
                        rd_d       = bus.Mux_1;
                        memtoreg_d = bus.MemtoReg;
                        regwrite_d = bus.RegWrite;
                    end
                end
            end
            S_WAIT: begin
                // An ack in the final allowed cycle still completes the access.
                if (bus.mem_ack) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = rd_q;
                    if (we_q) begin
                        wb_regwrite_d = 1'b0;
                    end else begin
                        wb_data_d     = memtoreg_q ? bus.mem_rdata : addr_q;
                        wb_regwrite_d = regwrite_q;
                    end
                end else if (cnt_q == LAST_WAIT_CNT) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + 4'd1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            we_q          <= 1'b0;
            rd_q          <= 5'd0;
            memtoreg_q    <= 1'b0;
            regwrite_q    <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= 32'd0;
            wb_reg_q      <= 5'd0;
            wb_regwrite_q <= 1'b0;
            pcsrc_q       <= 1'b0;
            br_tgt_q      <= 5'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            rd_q          <= rd_d;
            memtoreg_q    <= memtoreg_d;
            regwrite_q    <= regwrite_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_reg_q      <= wb_reg_d;
            wb_regwrite_q <= wb_regwrite_d;
            pcsrc_q       <= pcsrc_d;
            br_tgt_q      <= br_tgt_d;
            err_q         <= err_d;
        end
    end

    // Request strobes decode the state flop so reset drops them at once.
    assign bus.mem_req       = (state_q == S_WAIT);
    assign bus.mem_we        = (state_q == S_WAIT) & we_q;
    assign bus.stall         = (state_q == S_WAIT);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.wb_reg        = wb_reg_q;
    assign bus.wb_regwrite   = wb_regwrite_q;
    assign bus.PCSrc         = pcsrc_q;
    assign bus.branch_target = br_tgt_q;
    assign bus.mem_error     = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: writeback expectations queued at issue,
// popped and compared whenever wb_valid is seen.
module tb_mem_stage;

    logic clk;
    logic reset;
    mem_stage_if bus();

    mem_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rg;
        logic        rw;
        bit          chk_data;
    } wb_exp_t;

    wb_exp_t sb[$];
    wb_exp_t e;
    int checks = 0;
    int passed = 0;

    // Writeback monitor: every wb_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL wb_unexpected: got wb_valid data=%h reg=%0d rw=%b, required no writeback",
                         bus.wb_data, bus.wb_reg, bus.wb_regwrite);
            end else begin
                e = sb.pop_front();
                if ((e.chk_data && bus.wb_data !== e.data) || bus.wb_reg !== e.rg ||
                    bus.wb_regwrite !== e.rw)
                    $display("FAIL wb_fields: got data=%h reg=%0d rw=%b, required data=%h reg=%0d rw=%b",
                             bus.wb_data, bus.wb_reg, bus.wb_regwrite, e.data, e.rg, e.rw);
                else
                    passed++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.in_valid = 0; bus.Alu_resultado = 0; bus.Dato_2 = 0; bus.Mux_1 = 0;
        bus.Zero_flag = 0; bus.Sumador_resultado = 0; bus.MemRead = 0; bus.MemWrite = 0;
        bus.MemtoReg = 0; bus.RegWrite = 0; bus.Branch = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    endtask

    task automatic drive_op(input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd,
                            input logic mr, input logic mw, input logic m2r, input logic rw);
        bus.in_valid = 1; bus.Alu_resultado = alu; bus.Dato_2 = d2; bus.Mux_1 = rd;
        bus.MemRead = mr; bus.MemWrite = mw; bus.MemtoReg = m2r; bus.RegWrite = rw;
        bus.Branch = 0; bus.Zero_flag = 0;
    endtask

    // Called right after an op is driven; counts stall cycles, acks in cycle ack_at (0 = never).
    task automatic run_mem(input int ack_at, input logic [31:0] rd, input bit garbage,
                           output int n, output logic f_we, output logic [31:0] f_addr,
                           output logic [31:0] f_wdata);
        @(negedge clk);
        idle_inputs();
        if (garbage) drive_op(32'h77, 0, 5'd9, 0, 0, 0, 1);
        f_we = bus.mem_we; f_addr = bus.mem_addr; f_wdata = bus.mem_wdata;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.stall !== 1'b1) break;
            n++;
            if (n == 2) idle_inputs();
            if (n == ack_at) begin bus.mem_ack = 1; bus.mem_rdata = rd; end
            @(negedge clk);
            bus.mem_ack = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.wb_valid, bus.wb_regwrite, bus.PCSrc, bus.mem_error, bus.stall} !== 7'b0)
            $display("FAIL reset_flags: got %b, required 0000000",
                     {bus.mem_req, bus.mem_we, bus.wb_valid, bus.wb_regwrite, bus.PCSrc, bus.mem_error, bus.stall});
        else passed++;
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.wb_data} !== 96'd0)
            $display("FAIL reset_data: got addr=%h wdata=%h wb_data=%h, required all 0",
                     bus.mem_addr, bus.mem_wdata, bus.wb_data);
        else passed++;
        checks++;
        if ({bus.wb_reg, bus.branch_target} !== 10'd0)
            $display("FAIL reset_regs: got wb_reg=%0d target=%0d, required 0 0", bus.wb_reg, bus.branch_target);
        else passed++;
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        drive_op(32'h0000002A, 0, 5'd5, 0, 0, 0, 1);
        sb.push_back('{32'h2A, 5'd5, 1'b1, 1'b1});
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.wb_valid !== 1'b1) $display("FAIL alu_latency: got wb_valid=%b, required 1", bus.wb_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h2A)
            $display("FAIL alu_hold: got wb_valid=%b wb_data=%h, required 0 0000002a", bus.wb_valid, bus.wb_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 5; i++) begin
            v = $urandom;
            drive_op(v, $urandom, 5'(i + 10), 0, 0, 0, 1'(i & 1));
            sb.push_back('{v, 5'(i + 10), 1'(i & 1), 1'b1});
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
        else passed++;
    endtask

    task automatic test_load();
        int n; logic we; logic [31:0] a, w;
        drive_op(32'h100, 32'h0, 5'd7, 1, 0, 1, 1);
        sb.push_back('{32'hDEADBEEF, 5'd7, 1'b1, 1'b1});
        run_mem(4, 32'hDEADBEEF, 1'b1, n, we, a, w);
        checks++;
        if (n != 4) $display("FAIL load_stall: got %0d stall cycles, required 4", n);
        else passed++;
        checks++;
        if (we !== 1'b0 || a !== 32'h100) $display("FAIL load_bus: got we=%b addr=%h, required 0 00000100", we, a);
        else passed++;
        // Load without MemtoReg writes back the address itself.
        drive_op(32'h200, 32'h0, 5'd8, 1, 0, 0, 1);
        sb.push_back('{32'h200, 5'd8, 1'b1, 1'b1});
        run_mem(1, 32'h12345678, 1'b0, n, we, a, w);
        checks++;
        if (n != 1) $display("FAIL load_addr_stall: got %0d, required 1", n);
        else passed++;
    endtask

    task automatic test_store();
        int n; logic we; logic [31:0] a, w;
        drive_op(32'h10, 32'h55, 5'd3, 0, 1, 0, 1);
        sb.push_back('{32'h0, 5'd3, 1'b0, 1'b0});
        run_mem(2, 32'h0, 1'b0, n, we, a, w);
        checks++;
        if (we !== 1'b1 || w !== 32'h55 || a !== 32'h10)
            $display("FAIL store_bus: got we=%b wdata=%h addr=%h, required 1 00000055 00000010", we, w, a);
        else passed++;
        checks++;
        if (n != 2 || bus.mem_we !== 1'b0)
            $display("FAIL store_done: got stall=%0d mem_we=%b, required 2 0", n, bus.mem_we);
        else passed++;
    endtask

    task automatic test_ack_at_limit();
        int n; logic we; logic [31:0] a, w;
        drive_op(32'h40, 32'h0, 5'd4, 1, 0, 1, 1);
        sb.push_back('{32'hCAFE0001, 5'd4, 1'b1, 1'b1});
        run_mem(15, 32'hCAFE0001, 1'b0, n, we, a, w);
        checks++;
        if (n != 15 || bus.mem_error !== 1'b0)
            $display("FAIL ack_limit: got stall=%0d err=%b, required 15 0", n, bus.mem_error);
        else passed++;
    endtask

    task automatic test_timeout();
        int n; logic we; logic [31:0] a, w;
        drive_op(32'h80, 32'h0, 5'd6, 1, 0, 1, 1);
        run_mem(0, 32'h0, 1'b0, n, we, a, w);
        checks++;
        if (n != 15) $display("FAIL timeout_len: got %0d wait cycles, required 15", n);
        else passed++;
        checks++;
        if (bus.mem_error !== 1'b1 || bus.mem_req !== 1'b0)
            $display("FAIL timeout_err: got err=%b req=%b, required 1 0", bus.mem_error, bus.mem_req);
        else passed++;
        drive_op(32'h99, 0, 5'd2, 0, 0, 0, 1);
        sb.push_back('{32'h99, 5'd2, 1'b1, 1'b1});
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.mem_error !== 1'b1) $display("FAIL error_sticky: got %b, required 1", bus.mem_error);
        else passed++;
    endtask

    task automatic test_misaligned();
        bit seen_req;
        reset = 1;
        @(negedge clk);
        reset = 0;
        drive_op(32'h102, 0, 5'd1, 1, 0, 1, 1);
        seen_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) seen_req = 1;
        end
        checks++;
        if (seen_req || bus.mem_error !== 1'b1)
            $display("FAIL misaligned: got req_seen=%b err=%b, required 0 1", seen_req, bus.mem_error);
        else passed++;
    endtask

    task automatic test_branch();
        drive_op(32'h0, 0, 5'd0, 0, 0, 0, 0);
        bus.Branch = 1; bus.Zero_flag = 1; bus.Sumador_resultado = 5'd12;
        sb.push_back('{32'h0, 5'd0, 1'b0, 1'b1});
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.PCSrc !== 1'b1 || bus.branch_target !== 5'd12)
            $display("FAIL branch_taken: got pcsrc=%b target=%0d, required 1 12", bus.PCSrc, bus.branch_target);
        else passed++;
        drive_op(32'h0, 0, 5'd0, 0, 0, 0, 0);
        bus.Branch = 1; bus.Zero_flag = 0; bus.Sumador_resultado = 5'd20;
        sb.push_back('{32'h0, 5'd0, 1'b0, 1'b1});
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.PCSrc !== 1'b0 || bus.branch_target !== 5'd12)
            $display("FAIL branch_not_taken: got pcsrc=%b target=%0d, required 0 12", bus.PCSrc, bus.branch_target);
        else passed++;
    endtask

    task automatic test_reset_in_wait();
        bit seen_wb;
        drive_op(32'h300, 0, 5'd11, 1, 0, 1, 1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) $display("FAIL rst_wait_req: got %b before reset, required 1", bus.mem_req);
        else passed++;
        #2 reset = 1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0)
            $display("FAIL rst_async: got req=%b stall=%b, required 0 0", bus.mem_req, bus.stall);
        else passed++;
        bus.mem_ack = 1; bus.mem_rdata = 32'hBAD;
        @(negedge clk);
        reset = 0;
        idle_inputs();
        seen_wb = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.wb_valid !== 1'b0) seen_wb = 1;
        end
        checks++;
        if (seen_wb) $display("FAIL rst_no_wb: got wb_valid after aborted access, required none");
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_ack_at_limit();
        test_timeout();
        test_misaligned();
        test_branch();
        test_reset_in_wait();
        checks++;
        if (sb.size() != 0) $display("FAIL sb_empty: got %0d pending writebacks, required 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
